// File: rtl/long_divider_if.sv
// Request/result bundle for long_divider: the requester drives start/D/M,
// the divider returns the registered Q/R, status and error flags.
interface long_divider_if;
  logic       start;
  logic [6:0] D;
  logic [3:0] M;
  logic [3:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       ovf;
  logic       dbz;

  modport master (output start, D, M, input Q, R, busy, done, ovf, dbz);
  modport slave  (input start, D, M, output Q, R, busy, done, ovf, dbz);
endinterface

// File: rtl/long_divider.sv
// 7-bit / 4-bit restoring long divider, one dividend bit per clock, MSB first.
// Define LONG_DIVIDER_ERR_FLAGS_EN to drive the ovf/dbz flags; otherwise both read 0.
module long_divider (
  input  logic          clk,
  input  logic          rst,
  long_divider_if.slave div_if
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [6:0]  work_q;
  logic [3:0]  dsr_q;
  logic [3:0]  rem_q;
  logic [3:0]  q_q;
  logic [3:0]  r_q;
  logic        busy_q;
  logic        done_q;
  logic        ovf_q;
  logic        dbz_q;

  logic [4:0]  rem_shift;
  logic        fits;
  logic [3:0]  rem_d;
  logic [6:0]  work_d;

  // work_q shifts dividend bits out of the top while quotient bits enter at
  // the bottom, so after 7 steps it holds the full 7-bit quotient.
  always_comb begin
    rem_shift = {rem_q, work_q[6]};
    fits      = (rem_shift >= {1'b0, dsr_q});
    // The difference is below M whenever it is taken, so 4 bits suffice.
    rem_d     = fits ? (rem_shift[3:0] - dsr_q) : rem_shift[3:0];
    work_d    = {work_q[5:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      work_q  <= 7'd0;
      dsr_q   <= 4'd0;
      rem_q   <= 4'd0;
      q_q     <= 4'd0;
      r_q     <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (div_if.start) begin
            work_q  <= div_if.D;
            dsr_q   <= div_if.M;
            rem_q   <= 4'd0;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          work_q <= work_d;
          rem_q  <= rem_d;
          cnt_q  <= cnt_q + 3'd1;
          if (cnt_q == 3'd6) begin
            // With M == 0 every step "fits", giving Q = F and R = D[3:0].
            q_q     <= work_d[3:0];
            r_q     <= rem_d;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef LONG_DIVIDER_ERR_FLAGS_EN
            ovf_q   <= |work_d[6:4];
            dbz_q   <= (dsr_q == 4'd0);
`endif
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign div_if.Q    = q_q;
  assign div_if.R    = r_q;
  assign div_if.busy = busy_q;
  assign div_if.done = done_q;
  assign div_if.ovf  = ovf_q;
  assign div_if.dbz  = dbz_q;

endmodule

// File: tb/tb_long_divider.sv
// Randomised self-checking bench for long_divider against an arithmetic model
// (integer / and %), covering directed corner cases, reset abort and start races.
module tb_long_divider;

`ifdef LONG_DIVIDER_ERR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  long_divider_if bus ();

  long_divider dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [6:0] d, input logic [3:0] m,
                                output logic [3:0] eq, output logic [3:0] er,
                                output logic eo, output logic ez);
    int q;
    int r;
    if (m == 4'd0) begin
      eq = 4'hF;
      er = d[3:0];
      eo = FLAGS;
      ez = FLAGS;
    end else begin
      q  = int'(d) / int'(m);
      r  = int'(d) % int'(m);
      eq = q[3:0];
      er = r[3:0];
      eo = FLAGS && (q > 15);
      ez = 1'b0;
    end
  endfunction

  // Entered #1 after a rising edge with the divider idle. poke: re-pulse start
  // mid-run with other operands. chain: hold start high through the done cycle.
  task automatic do_div(input logic [6:0] d, input logic [3:0] m,
                        input bit poke, input bit chain);
    logic [3:0] eq, er;
    logic       eo, ez;
    bit         early;
    model(d, m, eq, er, eo, ez);
    bus.start = 1'b1;
    bus.D     = d;
    bus.M     = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.D     = 7'($urandom);
    bus.M     = 4'($urandom);
    check_eq("busy_after_accept", bus.busy, 1'b1);
    early = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (poke && k == 3) begin
        bus.start = 1'b1;
        bus.D     = 7'($urandom);
        bus.M     = 4'($urandom);
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) early = 1'b1;
    end
    check_eq("no_early_done", early, 1'b0);
    @(posedge clk); #1;
    $display("div D=%0d M=%0d -> Q=%0h R=%0h ovf=%0b dbz=%0b (exp Q=%0h R=%0h ovf=%0b dbz=%0b)",
             d, m, bus.Q, bus.R, bus.ovf, bus.dbz, eq, er, eo, ez);
    check_eq("done_pulse", bus.done, 1'b1);
    check_eq("busy_in_done", bus.busy, 1'b1);
    check_eq("Q", bus.Q, eq);
    check_eq("R", bus.R, er);
    check_eq("ovf", bus.ovf, eo);
    check_eq("dbz", bus.dbz, ez);
    if (chain) begin
      bus.start = 1'b1;
      bus.D     = 7'($urandom);
      bus.M     = 4'($urandom);
    end
    @(posedge clk); #1;
    check_eq("done_low_after", bus.done, 1'b0);
    check_eq("busy_low_after", bus.busy, 1'b0);
    check_eq("Q_hold", bus.Q, eq);
    check_eq("R_hold", bus.R, er);
  endtask

  initial begin
    logic [6:0] rd;
    logic [3:0] rm;
    bit         saw_done;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.D     = 7'd0;
    bus.M     = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_Q", bus.Q, 4'd0);
    check_eq("rst_R", bus.R, 4'd0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_done", bus.done, 1'b0);
    check_eq("rst_ovf", bus.ovf, 1'b0);
    check_eq("rst_dbz", bus.dbz, 1'b0);
    // Start asserted together with reset must not launch a division.
    bus.start = 1'b1;
    bus.D     = 7'd50;
    bus.M     = 4'd3;
    @(posedge clk); #1;
    check_eq("rst_over_start", bus.busy, 1'b0);
    bus.start = 1'b0;
    rst       = 1'b0;
    @(posedge clk); #1;

    do_div(7'd7,   4'd2, 1'b0, 1'b0);
    do_div(7'd6,   4'd2, 1'b0, 1'b0);
    do_div(7'd9,   4'd4, 1'b0, 1'b0);
    do_div(7'd12,  4'd5, 1'b0, 1'b0);
    do_div(7'd127, 4'd1, 1'b0, 1'b0);
    do_div(7'd13,  4'd0, 1'b0, 1'b0);
    do_div(7'd100, 4'd7, 1'b1, 1'b0);
    // Start held across done: ignored in DONE, accepted in the following IDLE cycle.
    do_div(7'd45,  4'd6, 1'b0, 1'b1);
    do_div(7'd120, 4'd11, 1'b0, 1'b0);

    // Reset mid-run abandons the division with no done pulse.
    bus.start = 1'b1;
    bus.D     = 7'd100;
    bus.M     = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_Q", bus.Q, 4'd0);
    check_eq("abort_R", bus.R, 4'd0);
    check_eq("abort_busy", bus.busy, 1'b0);
    check_eq("abort_done", bus.done, 1'b0);
    check_eq("abort_ovf", bus.ovf, 1'b0);
    check_eq("abort_dbz", bus.dbz, 1'b0);
    saw_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    check_eq("abort_no_activity", saw_done, 1'b0);
    do_div(7'd9, 4'd4, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rd = 7'($urandom);
      rm = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      do_div(rd, rm, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
